// File: rtl/binary_activation_repacker.sv
// binary_activation_repacker: binarizes signed elements against a threshold and repacks the bit stream into OUT_SIZE-wide beats (optional threshold port: BINARY_ACTIVATION_REPACKER_THRESHOLD_EN)
module binary_activation_repacker #(
   parameter int IN_WIDTH      = 8,
   parameter int IN_FRAC_WIDTH = 0,
   parameter int IN_SIZE       = 2,
   parameter int IN_DEPTH      = 4,
   parameter int OUT_SIZE      = 4,
   parameter int OUT_DEPTH     = IN_SIZE * IN_DEPTH / OUT_SIZE
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_in,
   input  logic                             data_in_valid,
   output logic                             data_in_ready,
`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
   input  logic [IN_WIDTH-1:0]              threshold,
`endif
   output logic [OUT_SIZE-1:0]              data_out,
   output logic                             data_out_valid,
   input  logic                             data_out_ready,
   output logic                             data_out_last
);
   localparam int CAP = IN_SIZE + OUT_SIZE;
   localparam int CW  = $clog2(CAP + 1);
   localparam int OBW = OUT_DEPTH > 1 ? $clog2(OUT_DEPTH) : 1;
   localparam int IBW = IN_DEPTH > 1 ? $clog2(IN_DEPTH) : 1;

   if ((IN_SIZE * IN_DEPTH) % OUT_SIZE != 0) begin : g_bad_ratio
      $error("IN_SIZE*IN_DEPTH must be divisible by OUT_SIZE");
   end
   if (IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH >= IN_WIDTH) begin : g_bad_frac
      $error("IN_FRAC_WIDTH must lie in 0..IN_WIDTH-1");
   end

   logic [IN_WIDTH-1:0] thr;
   logic [CAP-1:0]      bits, shifted, bits_next;
   logic [CW-1:0]       count, base, count_next;
   logic [OBW-1:0]      out_beat, out_beat_next;
   logic [IBW-1:0]      in_beat;
   logic [IN_SIZE-1:0]  new_bits;
   logic                in_fire, out_fire;

`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
   assign thr = threshold;
`else
   assign thr = '0;
`endif

   assign in_fire  = data_in_valid && data_in_ready;
   assign out_fire = data_out_valid && data_out_ready;
   assign data_out = bits[OUT_SIZE-1:0];

   // drop the consumed beat first, then append the new bits right above what remains
   always_comb begin
      new_bits = '0;
      for (int i = 0; i < IN_SIZE; i++) new_bits[i] = $signed(data_in[i]) >= $signed(thr);
      base          = out_fire ? count - CW'(OUT_SIZE) : count;
      shifted       = out_fire ? bits >> OUT_SIZE : bits;
      bits_next     = in_fire ? shifted | (CAP'(new_bits) << base) : shifted;
      count_next    = in_fire ? base + CW'(IN_SIZE) : base;
      out_beat_next = out_fire ? (out_beat == OBW'(OUT_DEPTH - 1) ? '0 : out_beat + 1'b1) : out_beat;
   end

   // buffer, frame counters and registered handshake flags derived from the next fill level
   always_ff @(posedge clk) begin
      if (rst) begin
         bits           <= '0;
         count          <= '0;
         out_beat       <= '0;
         in_beat        <= '0;
         data_in_ready  <= 1'b1;
         data_out_valid <= 1'b0;
         data_out_last  <= 1'b0;
      end else begin
         bits           <= bits_next;
         count          <= count_next;
         out_beat       <= out_beat_next;
         if (in_fire) in_beat <= in_beat == IBW'(IN_DEPTH - 1) ? '0 : in_beat + 1'b1;
         data_in_ready  <= count_next <= CW'(CAP - IN_SIZE);
         data_out_valid <= count_next >= CW'(OUT_SIZE);
         data_out_last  <= count_next >= CW'(OUT_SIZE) && out_beat_next == OBW'(OUT_DEPTH - 1);
      end
   end

   // occupancy stays bounded and agrees with the frame position seen on both sides
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (int'(count) <= CAP);
         assert ((int'(in_beat) * IN_SIZE - int'(out_beat) * OUT_SIZE - int'(count)) % (IN_SIZE * IN_DEPTH) == 0);
      end
   end
endmodule

// File: tb/tb_binary_activation_repacker.sv
// tb_binary_activation_repacker: directed and randomized checks of the repacker against a bit-queue model
module tb_binary_activation_repacker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [1:0][7:0] a_din = '0;
   logic            a_iv = 1'b0, a_or = 1'b1, a_ir, a_ov, a_last;
   logic [3:0]      a_dout;
   logic [3:0][7:0] b_din = '0;
   logic            b_iv = 1'b0, b_or = 1'b1, b_ir, b_ov, b_last;
   logic [3:0]      b_dout;
   logic [2:0][7:0] c_din = '0;
   logic            c_iv = 1'b0, c_or = 1'b1, c_ir, c_ov, c_last;
   logic [1:0]      c_dout;
`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
   logic [7:0]      a_thr = '0, thr0 = '0, thr1 = '0;
`endif

   logic signed [7:0] st [8];
   logic [3:0]        got [$];
   logic              lasts [$];
   int                fire2, first_v, unstable;
   logic              ir3;

   binary_activation_repacker u_a (
      .clk(clk), .rst(rst), .data_in(a_din), .data_in_valid(a_iv), .data_in_ready(a_ir),
`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
      .threshold(a_thr),
`endif
      .data_out(a_dout), .data_out_valid(a_ov), .data_out_ready(a_or), .data_out_last(a_last));

   binary_activation_repacker #(.IN_SIZE(4), .IN_DEPTH(1), .OUT_SIZE(4)) u_b (
      .clk(clk), .rst(rst), .data_in(b_din), .data_in_valid(b_iv), .data_in_ready(b_ir),
`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
      .threshold(8'h00),
`endif
      .data_out(b_dout), .data_out_valid(b_ov), .data_out_ready(b_or), .data_out_last(b_last));

   binary_activation_repacker #(.IN_SIZE(3), .IN_DEPTH(2), .OUT_SIZE(2)) u_c (
      .clk(clk), .rst(rst), .data_in(c_din), .data_in_valid(c_iv), .data_in_ready(c_ir),
`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
      .threshold(8'h00),
`endif
      .data_out(c_dout), .data_out_valid(c_ov), .data_out_ready(c_or), .data_out_last(c_last));

   task automatic do_reset;
      rst = 1'b1;
      a_iv = 1'b0;
      b_iv = 1'b0;
      c_iv = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic a_stream(input int stall);
      int bi = 0;
      int cyc = 0;
      logic held = 1'b0;
      logic seen3 = 1'b0;
      logic [3:0] prev = '0;
      got.delete();
      lasts.delete();
      fire2 = -1;
      first_v = -1;
      unstable = 0;
      ir3 = 1'bx;
      while ((bi < 4 || got.size() < 2) && cyc < 60) begin
         @(negedge clk);
         if (a_ov && first_v < 0) first_v = cyc;
         if (held && a_dout !== prev) unstable++;
         if (bi == 3 && !seen3) begin
            ir3 = a_ir;
            seen3 = 1'b1;
         end
         a_or = cyc >= stall;
         a_iv = bi < 4;
         if (bi < 4) a_din = {st[2*bi+1], st[2*bi]};
`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
         a_thr = bi < 2 ? thr0 : thr1;
`endif
         held = a_ov && !a_or;
         prev = a_dout;
         if (a_ov && a_or) begin
            got.push_back(a_dout);
            lasts.push_back(a_last);
         end
         if (a_iv && a_ir) begin
            if (bi == 1) fire2 = cyc;
            bi++;
         end
         cyc++;
      end
      @(negedge clk);
      a_iv = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_ir); end
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_ov); end
      checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", a_last); end
      checks++; if (a_dout !== 4'b0000) begin errors++; $display("FAIL reset_data: got %b want 0000", a_dout); end
      checks++; if (b_ov !== 1'b0 || b_ir !== 1'b1) begin errors++; $display("FAIL reset_b: got v=%b r=%b want v=0 r=1", b_ov, b_ir); end
      checks++; if (c_ov !== 1'b0 || c_ir !== 1'b1) begin errors++; $display("FAIL reset_c: got v=%b r=%b want v=0 r=1", c_ov, c_ir); end
   endtask

   task automatic check_default_stream(input string tag);
      checks++;
      if (got.size() != 2) begin
         errors++; $display("FAIL %s_count: got %0d beats want 2", tag, got.size());
      end else begin
         checks++; if (got[0] !== 4'b0101) begin errors++; $display("FAIL %s_out0: got %b want 0101", tag, got[0]); end
         checks++; if (lasts[0] !== 1'b0) begin errors++; $display("FAIL %s_last0: got %b want 0", tag, lasts[0]); end
         checks++; if (got[1] !== 4'b1001) begin errors++; $display("FAIL %s_out1: got %b want 1001", tag, got[1]); end
         checks++; if (lasts[1] !== 1'b1) begin errors++; $display("FAIL %s_last1: got %b want 1", tag, lasts[1]); end
      end
   endtask

   task automatic test_defaults;
      st = '{8'sd3, -8'sd1, 8'sd0, 8'h80, 8'sd127, -8'sd5, -8'sd2, 8'sd1};
      do_reset();
      a_stream(0);
      check_default_stream("defaults");
      checks++; if (first_v != fire2 + 1) begin errors++; $display("FAIL defaults_latency: first valid cycle %0d want %0d", first_v, fire2 + 1); end
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL defaults_drained: valid %b want 0", a_ov); end
   endtask

   task automatic test_backpressure;
      do_reset();
      a_stream(10);
      check_default_stream("backpressure");
      checks++; if (ir3 !== 1'b0) begin errors++; $display("FAIL backpressure_full: in_ready %b want 0 after third beat", ir3); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL backpressure_hold: %0d changes while stalled want 0", unstable); end
   endtask

   task automatic test_reset_mid_frame;
      do_reset();
      a_or = 1'b1;
      a_din = {8'sd5, 8'sd5};
      a_iv = 1'b1;
      @(negedge clk);
      a_iv = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", a_ov); end
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", a_ir); end
      a_stream(0);
      check_default_stream("midreset");
   endtask

   task automatic test_back_to_back;
      logic [3:0] eq [$];
      logic [3:0] e, exp;
      int nin = 0, nout = 0, cyc = 0, ic0 = -1, icn = -1, oc0 = -1, ocn = -1;
      do_reset();
      b_or = 1'b1;
      while (nout < 3 && cyc < 30) begin
         @(negedge clk);
         b_iv = nin < 3;
         for (int i = 0; i < 4; i++) b_din[i] = 8'($urandom);
         if (b_ov && b_or) begin
            exp = eq.size() > 0 ? eq.pop_front() : 4'bxxxx;
            checks++; if (b_dout !== exp) begin errors++; $display("FAIL b2b_data%0d: got %b want %b", nout, b_dout, exp); end
            checks++; if (b_last !== 1'b1) begin errors++; $display("FAIL b2b_last%0d: got %b want 1", nout, b_last); end
            if (oc0 < 0) oc0 = cyc;
            ocn = cyc;
            nout++;
         end
         if (b_iv && b_ir) begin
            for (int i = 0; i < 4; i++) e[i] = $signed(b_din[i]) >= 0;
            eq.push_back(e);
            if (ic0 < 0) ic0 = cyc;
            icn = cyc;
            nin++;
         end
         cyc++;
      end
      b_iv = 1'b0;
      checks++; if (nout != 3) begin errors++; $display("FAIL b2b_count: got %0d beats want 3", nout); end
      checks++; if (icn - ic0 != 2 || ocn - oc0 != 2) begin errors++; $display("FAIL b2b_rate: in span %0d out span %0d want 2 and 2", icn - ic0, ocn - oc0); end
      checks++; if (oc0 != ic0 + 1) begin errors++; $display("FAIL b2b_latency: first out cycle %0d want %0d", oc0, ic0 + 1); end
   endtask

   task automatic test_random;
      bit q [$];
      int nin = 0, nout = 0, cyc = 0;
      logic ir0;
      logic [1:0] exp;
      do_reset();
      while (nout < 3000 && cyc < 40000 && errors < 40) begin
         @(negedge clk);
         checks++; if (c_ir !== (q.size() + 3 <= 5)) begin errors++; $display("FAIL random_ready: got %b fill %0d", c_ir, q.size()); end
         checks++; if (c_ov !== (q.size() >= 2)) begin errors++; $display("FAIL random_valid: got %b fill %0d", c_ov, q.size()); end
         c_or = $urandom_range(0, 3) != 0;
         c_iv = nin < 2000 && $urandom_range(0, 2) != 0;
         for (int i = 0; i < 3; i++) c_din[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2) - 1) : 8'($urandom);
         ir0 = c_ir;
         c_or = !c_or;
         #1;
         checks++; if (c_ir !== ir0) begin errors++; $display("FAIL random_ready_path: got %b want %b after ready toggle", c_ir, ir0); end
         c_or = !c_or;
         #1;
         if (c_ov && c_or) begin
            exp = q.size() >= 2 ? {q[1], q[0]} : 2'bxx;
            checks++; if (c_dout !== exp) begin errors++; $display("FAIL random_data%0d: got %b want %b", nout, c_dout, exp); end
            checks++; if (c_last !== (nout % 3 == 2)) begin errors++; $display("FAIL random_last%0d: got %b want %b", nout, c_last, nout % 3 == 2); end
            if (q.size() >= 2) begin
               void'(q.pop_front());
               void'(q.pop_front());
            end
            nout++;
         end
         if (c_iv && c_ir) begin
            for (int i = 0; i < 3; i++) q.push_back($signed(c_din[i]) >= 0);
            nin++;
         end
         cyc++;
      end
      c_iv = 1'b0;
      checks++; if (nout != 3000) begin errors++; $display("FAIL random_count: got %0d beats want 3000", nout); end
   endtask

   task automatic test_threshold;
      logic [3:0] e0, e1;
      logic signed [7:0] t0, t1;
`ifdef BINARY_ACTIVATION_REPACKER_THRESHOLD_EN
      thr0 = 8'sd5;
      thr1 = -8'sd2;
      t0 = thr0;
      t1 = thr1;
`else
      t0 = 8'sd0;
      t1 = 8'sd0;
`endif
      st = '{8'sd5, 8'sd4, 8'sd6, -8'sd7, 8'sd0, 8'sd10, -8'sd1, -8'sd3};
      for (int i = 0; i < 4; i++) begin
         e0[i] = st[i] >= t0;
         e1[i] = st[i+4] >= t1;
      end
      do_reset();
      a_stream(0);
      checks++;
      if (got.size() != 2) begin
         errors++; $display("FAIL threshold_count: got %0d beats want 2", got.size());
      end else begin
         checks++; if (got[0] !== e0) begin errors++; $display("FAIL threshold_out0: got %b want %b", got[0], e0); end
         checks++; if (got[1] !== e1) begin errors++; $display("FAIL threshold_out1: got %b want %b", got[1], e1); end
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_backpressure();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      test_threshold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
